// File: rtl/rx_iq_scheduler_pkg.sv
// Shared widths, FSM state encoding and IQ packing helper for the RX IQ
// scheduler and its per-channel holding logic.
package rx_iq_scheduler_pkg;

  localparam int IQ_W   = 24;  // one I or Q component
  localparam int FIFO_W = 48;  // packed {Q, I} FIFO word
  localparam int OVR_W  = 16;  // dropped-sample counter

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } state_t;

  // FIFO word layout: Q in the upper half, I in the lower half.
  function automatic logic [FIFO_W-1:0] pack_iq(input logic [IQ_W-1:0] i,
                                                input logic [IQ_W-1:0] q);
    return {q, i};
  endfunction

endpackage

// File: rtl/rx_iq_scheduler_if.sv
// Downstream IQ FIFO write port.
//   fifo_wr   : one-cycle write strobe
//   fifo_data : {Q[23:0], I[23:0]}
//   fifo_ch   : channel tag, 0 = RX1, 1 = RX2
//   fifo_full : FIFO cannot accept a write this cycle
// master = scheduler side, slave = FIFO side.
interface rx_iq_scheduler_if;
  import rx_iq_scheduler_pkg::*;

  logic              fifo_wr;
  logic [FIFO_W-1:0] fifo_data;
  logic              fifo_ch;
  logic              fifo_full;

  modport master (output fifo_wr, output fifo_data, output fifo_ch, input fifo_full);
  modport slave  (input fifo_wr, input fifo_data, input fifo_ch, output fifo_full);

endinterface

// File: rtl/rx_iq_hold.sv
// One channel's sample holding register with pending flag.
//   clk_in, reset_n : clock, asynchronous active-low reset
//   en              : channel enable
//   valid, sample   : incoming packed IQ sample and its strobe
//   clr             : scheduler is writing the held sample this cycle
//   pend, hold      : pending flag and held sample
//   drop            : a sample is being discarded this cycle (overrun)
module rx_iq_hold
  import rx_iq_scheduler_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              en,
  input  logic              valid,
  input  logic [FIFO_W-1:0] sample,
  input  logic              clr,
  output logic              pend,
  output logic [FIFO_W-1:0] hold,
  output logic              drop
);

  logic              pend_reg;
  logic [FIFO_W-1:0] hold_reg;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg <= 1'b0;
      hold_reg <= '0;
    end else if (!en) begin
      // A disabled channel never holds a sample for the scheduler.
      pend_reg <= 1'b0;
    end else if (valid && (!pend_reg || clr)) begin
      // The slot is free, or is being emptied by a write on this same edge.
      hold_reg <= sample;
      pend_reg <= 1'b1;
    end else if (clr) begin
      pend_reg <= 1'b0;
    end
  end

  assign drop = en && valid && pend_reg && !clr;
  assign pend = pend_reg;
  assign hold = hold_reg;

endmodule

// File: rtl/rx_iq_scheduler.sv
// Merges the two decimated RX IQ streams into a single tagged FIFO stream.
//   clk_in, reset_n         : clock, asynchronous active-low reset
//   RX1_I/Q/valid           : RX1 sample and strobe
//   RX2_I/Q/valid           : RX2 sample and strobe
//   rx1, rx2                : channel enables
//   overrun_clear           : clears the dropped-sample counter
//   fifo                    : FIFO write port (wr/data/ch out, full in)
//   iq_overrun, overrun_cnt : sticky overrun flag and saturating drop count
// In dual mode a frame is emitted only when both channels hold a sample,
// always RX1 first, so the host can de-interleave by position.
module rx_iq_scheduler
  import rx_iq_scheduler_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic signed [IQ_W-1:0] RX1_I,
  input  logic signed [IQ_W-1:0] RX1_Q,
  input  logic                   RX1_valid,
  input  logic signed [IQ_W-1:0] RX2_I,
  input  logic signed [IQ_W-1:0] RX2_Q,
  input  logic                   RX2_valid,
  input  logic                   rx1,
  input  logic                   rx2,
  input  logic                   overrun_clear,
  rx_iq_scheduler_if.master      fifo,
  output logic                   iq_overrun,
  output logic [OVR_W-1:0]       overrun_cnt
);

  logic [1:0]        ch_en;
  logic [1:0]        ch_valid;
  logic [1:0]        ch_clr;
  logic [1:0]        ch_pend;
  logic [1:0]        ch_drop;
  logic [FIFO_W-1:0] ch_sample [2];
  logic [FIFO_W-1:0] ch_hold   [2];

  assign ch_en        = {rx2, rx1};
  assign ch_valid     = {RX2_valid, RX1_valid};
  assign ch_sample[0] = pack_iq(RX1_I, RX1_Q);
  assign ch_sample[1] = pack_iq(RX2_I, RX2_Q);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hold
      rx_iq_hold u_hold (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .en     (ch_en[gi]),
        .valid  (ch_valid[gi]),
        .sample (ch_sample[gi]),
        .clr    (ch_clr[gi]),
        .pend   (ch_pend[gi]),
        .hold   (ch_hold[gi]),
        .drop   (ch_drop[gi])
      );
    end
  endgenerate

  // Write scheduler
  state_t            state_reg, state_next;
  logic              wr_reg, wr_next;
  logic [FIFO_W-1:0] data_reg, data_next;
  logic              ch_reg, ch_next;
  logic              dual;

  assign dual = rx1 && rx2;

  always_comb begin
    state_next = state_reg;
    wr_next    = 1'b0;
    data_next  = data_reg;
    ch_next    = ch_reg;
    ch_clr     = 2'b00;
    case (state_reg)
      IDLE: begin
        if (dual) begin
          if (ch_pend[0] && ch_pend[1]) state_next = WR1;
        end else if (rx1) begin
          if (ch_pend[0]) state_next = WR1;
        end else if (rx2) begin
          if (ch_pend[1]) state_next = WR2;
        end
      end
      WR1: begin
        if (!rx1) begin
          state_next = IDLE;
        end else if (!fifo.fifo_full) begin
          wr_next    = 1'b1;
          data_next  = ch_hold[0];
          ch_next    = 1'b0;
          ch_clr[0]  = 1'b1;
          state_next = dual ? WR2 : IDLE;
        end
      end
      WR2: begin
        // Losing RX2 mid-frame abandons its half rather than writing stale data.
        if (!rx2) begin
          state_next = IDLE;
        end else if (!fifo.fifo_full) begin
          wr_next    = 1'b1;
          data_next  = ch_hold[1];
          ch_next    = 1'b1;
          ch_clr[1]  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      wr_reg    <= 1'b0;
      data_reg  <= '0;
      ch_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_reg    <= wr_next;
      data_reg  <= data_next;
      ch_reg    <= ch_next;
    end
  end

  assign fifo.fifo_wr   = wr_reg;
  assign fifo.fifo_data = data_reg;
  assign fifo.fifo_ch   = ch_reg;

  // Overrun accounting: both channels may drop on the same edge.
  logic [OVR_W-1:0] ovr_cnt_reg, ovr_cnt_next;
  logic [OVR_W:0]   ovr_sum;

  always_comb begin
    ovr_sum = {1'b0, ovr_cnt_reg}
            + {{OVR_W{1'b0}}, ch_drop[0]}
            + {{OVR_W{1'b0}}, ch_drop[1]};
    if (overrun_clear)     ovr_cnt_next = '0;
    else if (ovr_sum[OVR_W]) ovr_cnt_next = '1;
    else                   ovr_cnt_next = ovr_sum[OVR_W-1:0];
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) ovr_cnt_reg <= '0;
    else          ovr_cnt_reg <= ovr_cnt_next;
  end

  assign overrun_cnt = ovr_cnt_reg;
  assign iq_overrun  = |ovr_cnt_reg;

endmodule

// File: tb/tb_rx_iq_scheduler.sv
// Directed bench for rx_iq_scheduler: a table of single-channel
// transactions plus hand-written dual, stall, overrun and reset sequences.
module tb_rx_iq_scheduler;

  logic        clk_in;
  logic        reset_n;
  logic [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic        RX1_valid, RX2_valid;
  logic        rx1, rx2;
  logic        overrun_clear;
  logic        iq_overrun;
  logic [15:0] overrun_cnt;

  rx_iq_scheduler_if fifo_if ();

  rx_iq_scheduler dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .RX1_I        (RX1_I),
    .RX1_Q        (RX1_Q),
    .RX1_valid    (RX1_valid),
    .RX2_I        (RX2_I),
    .RX2_Q        (RX2_Q),
    .RX2_valid    (RX2_valid),
    .rx1          (rx1),
    .rx2          (rx2),
    .overrun_clear(overrun_clear),
    .fifo         (fifo_if),
    .iq_overrun   (iq_overrun),
    .overrun_cnt  (overrun_cnt)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    bit          chan;      // 0 = RX1 enabled only, 1 = RX2 enabled only
    logic [23:0] i;
    logic [23:0] q;
    logic [47:0] exp_data;
    bit          exp_ch;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int wr_seen;

    vecs[0] = '{chan: 1'b0, i: 24'h000123, q: 24'hFFFF00, exp_data: 48'hFFFF00_000123, exp_ch: 1'b0};
    vecs[1] = '{chan: 1'b1, i: 24'h7FFFFF, q: 24'h800000, exp_data: 48'h800000_7FFFFF, exp_ch: 1'b1};
    vecs[2] = '{chan: 1'b0, i: 24'hFFFFFF, q: 24'h000000, exp_data: 48'h000000_FFFFFF, exp_ch: 1'b0};
    vecs[3] = '{chan: 1'b1, i: 24'hABCDEF, q: 24'h123456, exp_data: 48'h123456_ABCDEF, exp_ch: 1'b1};
    vecs[4] = '{chan: 1'b0, i: 24'h800001, q: 24'h7FFFFE, exp_data: 48'h7FFFFE_800001, exp_ch: 1'b0};

    reset_n = 1'b0;
    RX1_I = '0; RX1_Q = '0; RX2_I = '0; RX2_Q = '0;
    RX1_valid = 1'b0; RX2_valid = 1'b0;
    rx1 = 1'b0; rx2 = 1'b0;
    overrun_clear = 1'b0;
    fifo_if.fifo_full = 1'b0;

    // Reset state
    step();
    step();
    check("reset_fifo_wr",    fifo_if.fifo_wr,   0);
    check("reset_fifo_data",  fifo_if.fifo_data, 0);
    check("reset_fifo_ch",    fifo_if.fifo_ch,   0);
    check("reset_overrun_cnt", overrun_cnt,      0);
    check("reset_iq_overrun", iq_overrun,        0);
    reset_n = 1'b1;
    step();

    // Single-channel transactions; the disabled channel strobes too and must be ignored.
    for (int v = 0; v < 5; v++) begin
      rx1 = (vecs[v].chan == 1'b0);
      rx2 = (vecs[v].chan == 1'b1);
      step();
      step();
      RX1_I = vecs[v].i; RX1_Q = vecs[v].q;
      RX2_I = vecs[v].i; RX2_Q = vecs[v].q;
      RX1_valid = 1'b1; RX2_valid = 1'b1;
      step();  // edge that samples valid
      RX1_valid = 1'b0; RX2_valid = 1'b0;
      step();
      check("single_wr_plus1", fifo_if.fifo_wr, 0);
      step();
      check("single_wr_plus2", fifo_if.fifo_wr, 1);
      check("single_data",     fifo_if.fifo_data, vecs[v].exp_data);
      check("single_ch",       fifo_if.fifo_ch, vecs[v].exp_ch);
      step();
      check("single_wr_plus3", fifo_if.fifo_wr, 0);
      $display("vector %0d: ch=%0d data=%012h wr=%0d", v, fifo_if.fifo_ch,
               fifo_if.fifo_data, fifo_if.fifo_wr);
    end

    // Dual mode: RX2 at cycle 0, RX1 at cycle 3 -> writes at cycles 5 and 6.
    rx1 = 1'b1; rx2 = 1'b1;
    step();
    step();
    RX2_I = 24'h111111; RX2_Q = 24'h222222;
    RX1_I = 24'h333333; RX1_Q = 24'h444444;
    for (int c = 0; c < 8; c++) begin
      RX2_valid = (c == 0);
      RX1_valid = (c == 3);
      step();
      check("dual_wr", fifo_if.fifo_wr, (c == 5 || c == 6) ? 1 : 0);
      if (c == 5) begin
        check("dual_first_ch",   fifo_if.fifo_ch, 0);
        check("dual_first_data", fifo_if.fifo_data, 48'h444444_333333);
      end
      if (c == 6) begin
        check("dual_second_ch",   fifo_if.fifo_ch, 1);
        check("dual_second_data", fifo_if.fifo_data, 48'h222222_111111);
      end
    end
    RX1_valid = 1'b0; RX2_valid = 1'b0;
    $display("dual frame done");

    // Dual mode with fifo_full held for 10 cycles while entering WR1.
    fifo_if.fifo_full = 1'b1;
    RX1_I = 24'h0A0A0A; RX1_Q = 24'h0B0B0B;
    RX2_I = 24'h0C0C0C; RX2_Q = 24'h0D0D0D;
    RX1_valid = 1'b1; RX2_valid = 1'b1;
    wr_seen = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      RX1_valid = 1'b0; RX2_valid = 1'b0;
      if (fifo_if.fifo_wr) wr_seen++;
    end
    check("stall_no_write", wr_seen, 0);
    fifo_if.fifo_full = 1'b0;
    step();
    check("stall_rel_wr1",   fifo_if.fifo_wr, 1);
    check("stall_rel_ch1",   fifo_if.fifo_ch, 0);
    check("stall_rel_data1", fifo_if.fifo_data, 48'h0B0B0B_0A0A0A);
    step();
    check("stall_rel_wr2",   fifo_if.fifo_wr, 1);
    check("stall_rel_ch2",   fifo_if.fifo_ch, 1);
    check("stall_rel_data2", fifo_if.fifo_data, 48'h0D0D0D_0C0C0C);
    step();
    check("stall_after_wr",  fifo_if.fifo_wr, 0);
    $display("stall frame done");

    // Three RX1 strobes during a stall: two drops, first sample kept.
    rx1 = 1'b1; rx2 = 1'b0;
    fifo_if.fifo_full = 1'b1;
    RX1_Q = 24'h000000;
    for (int e = 0; e < 6; e++) begin
      RX1_valid = (e == 0 || e == 2 || e == 4);
      RX1_I = (e == 0) ? 24'h00000A : (e == 2) ? 24'h00000B : 24'h00000C;
      step();
    end
    RX1_valid = 1'b0;
    check("ovr_cnt_two",   overrun_cnt, 2);
    check("ovr_flag_set",  iq_overrun, 1);
    check("ovr_stall_wr",  fifo_if.fifo_wr, 0);
    fifo_if.fifo_full = 1'b0;
    step();
    check("ovr_wr",        fifo_if.fifo_wr, 1);
    check("ovr_kept_first", fifo_if.fifo_data, 48'h000000_00000A);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    check("ovr_clear_cnt",  overrun_cnt, 0);
    check("ovr_clear_flag", iq_overrun, 0);
    $display("overrun sequence done");

    // Saturation: both channels drop every cycle while stalled.
    rx1 = 1'b1; rx2 = 1'b1;
    fifo_if.fifo_full = 1'b1;
    RX1_valid = 1'b1; RX2_valid = 1'b1;
    for (int e = 0; e < 32770; e++) step();
    check("ovr_saturate", overrun_cnt, 16'hFFFF);
    check("ovr_sat_flag", iq_overrun, 1);
    // Clear on the same edge as drops: the clear wins.
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    check("ovr_clear_wins", overrun_cnt, 0);
    $display("saturation sequence done");

    // Move into WR2 with both channels pending, then reset mid-frame.
    RX2_valid = 1'b0;
    fifo_if.fifo_full = 1'b0;
    step();  // WR1 writes; RX1 refills on the same edge
    RX1_valid = 1'b0;
    fifo_if.fifo_full = 1'b1;
    check("pre_reset_wr", fifo_if.fifo_wr, 1);
    check("pre_reset_ch", fifo_if.fifo_ch, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_wr",   fifo_if.fifo_wr, 0);
    check("async_reset_data", fifo_if.fifo_data, 0);
    check("async_reset_ch",   fifo_if.fifo_ch, 0);
    check("async_reset_cnt",  overrun_cnt, 0);
    check("async_reset_flag", iq_overrun, 0);
    step();
    reset_n = 1'b1;
    fifo_if.fifo_full = 1'b0;
    wr_seen = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      if (fifo_if.fifo_wr) wr_seen++;
    end
    check("post_reset_no_write", wr_seen, 0);

    // First post-reset frame comes from fresh samples only.
    RX1_I = 24'h5A5A5A; RX1_Q = 24'hA5A5A5;
    RX2_I = 24'h123123; RX2_Q = 24'h456456;
    RX1_valid = 1'b1; RX2_valid = 1'b1;
    step();
    RX1_valid = 1'b0; RX2_valid = 1'b0;
    step();
    step();
    check("post_reset_wr1",   fifo_if.fifo_wr, 1);
    check("post_reset_data1", fifo_if.fifo_data, 48'hA5A5A5_5A5A5A);
    check("post_reset_ch1",   fifo_if.fifo_ch, 0);
    step();
    check("post_reset_wr2",   fifo_if.fifo_wr, 1);
    check("post_reset_data2", fifo_if.fifo_data, 48'h456456_123123);
    check("post_reset_ch2",   fifo_if.fifo_ch, 1);
    step();
    check("post_reset_idle",  fifo_if.fifo_wr, 0);
    $display("reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_iq_scheduler.md
RX_IQ_SCHEDULER -- requirements
Module: rx_iq_scheduler

Interface
REQ-001 SHALL have port clk_in, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have ports RX1_I and RX1_Q, input, 24 signed each, RX1 decimated IQ sample.
REQ-004 SHALL have port RX1_valid, input, 1, one-cycle strobe qualifying RX1_I/RX1_Q.
REQ-005 SHALL have ports RX2_I and RX2_Q, input, 24 signed each, RX2 decimated IQ sample.
REQ-006 SHALL have port RX2_valid, input, 1, one-cycle strobe qualifying RX2_I/RX2_Q.
REQ-007 SHALL have ports rx1 and rx2, input, 1 each, channel enables from the parameter word.
REQ-008 SHALL have port fifo_full, input, 1, downstream IQ FIFO cannot accept a write.
REQ-009 SHALL have port overrun_clear, input, 1, synchronous clear of overrun state.
REQ-010 SHALL have port fifo_wr, output, 1, registered one-cycle write strobe.
REQ-011 SHALL have port fifo_data, output, 48, registered {Q[23:0], I[23:0]}; Q in the upper half.
REQ-012 SHALL have port fifo_ch, output, 1, channel tag: 0 = RX1, 1 = RX2.
REQ-013 SHALL have port iq_overrun, output, 1, sticky; high while overrun_cnt is nonzero.
REQ-014 SHALL have port overrun_cnt, output, 16 unsigned, count of dropped samples.

Function
REQ-015 SHALL keep one holding register plus a pending flag per channel.
REQ-016 SHALL capture a sample on valid when its channel is enabled and the pending flag is clear (or is being cleared by a write in the same cycle), and set pending.
REQ-017 SHALL drop a sample that arrives while pending is set and not being cleared, keep the held sample, and increment overrun_cnt.
REQ-018 SHALL ignore valid from a disabled channel and clear that channel's pending flag on the cycle after its enable drops.
REQ-019 SHALL implement FSM states IDLE, WR1 and WR2.
REQ-020 IDLE transitions: dual mode (rx1 and rx2) goes to WR1 only when both pending flags are set; RX1-only goes to WR1 when pend1 is set; RX2-only goes to WR2 when pend2 is set; otherwise stay in IDLE.
REQ-021 In WR1 with fifo_full low, SHALL register fifo_wr=1, fifo_data=hold1, fifo_ch=0 and clear pend1, then go to WR2 in dual mode or to IDLE otherwise.
REQ-022 In WR2 with fifo_full low, SHALL register fifo_wr=1, fifo_data=hold2, fifo_ch=1 and clear pend2, then go to IDLE.
REQ-023 In WR1 or WR2 with fifo_full high, SHALL hold the state with fifo_wr=0; no write is lost or duplicated.
REQ-024 In dual mode, SHALL emit RX1 then RX2 back-to-back when the FIFO is not full, so frame order always matches the host read order.
REQ-025 If rx2 drops while in WR2, SHALL abort to IDLE without writing.
REQ-026 Latency: fifo_wr SHALL assert exactly 2 clocks after the edge that sampled valid (single mode, FIFO not full, FSM in IDLE).
REQ-027 fifo_wr SHALL be low on every cycle outside a qualifying WR1 or WR2 write.
REQ-028 overrun_cnt SHALL saturate at 65535.
REQ-029 When overrun_clear and a drop occur in the same cycle, overrun_clear SHALL win and the count SHALL be 0.

Reset
REQ-030 reset_n low SHALL asynchronously force: state IDLE; pending flags 0; hold registers 0; fifo_wr 0; fifo_data 0; fifo_ch 0; overrun_cnt 0; iq_overrun 0.
REQ-031 Reset mid-write SHALL discard held samples; the first post-reset write SHALL come from a sample captured after reset release.

Structure
REQ-032 A shared package SHALL hold IQ_W=24, FIFO_W=48, OVR_W=16 and the FSM state enum.
REQ-033 A single sub-module, rx_iq_hold, SHALL implement one channel's capture/pending/drop logic and be instantiated twice.

Verification
REQ-034 RX1-only: one RX1_valid with I=0x000123, Q=0xFFFF00 -> fifo_wr exactly 2 clocks later, fifo_data=0xFFFF00000123, fifo_ch=0.
REQ-035 Dual: RX2_valid at cycle 0, RX1_valid at cycle 3 -> two consecutive writes, ch 0 then ch 1, the first at cycle 5.
REQ-036 Dual with fifo_full high for 10 cycles entering WR1 -> no write during the stall; RX1 then RX2 written immediately after release.
REQ-037 Three RX1_valid strobes during a fifo_full stall -> overrun_cnt=2, iq_overrun=1, and the first sample is the one written; then overrun_clear -> 0.
REQ-038 reset_n pulsed low while in WR2 with both pending -> all outputs 0 immediately, no write after release until a new valid.
